// File: rtl/spi_pkg.sv
// Shared register map, bit positions and shifter state type for the Wishbone SPI master.
package spi_pkg;

  localparam logic [7:0] DefaultDiv = 8'd3;

  localparam logic [2:0] AdrCtrl   = 3'd0;
  localparam logic [2:0] AdrClkdiv = 3'd1;
  localparam logic [2:0] AdrTx     = 3'd2;
  localparam logic [2:0] AdrRx     = 3'd3;
  localparam logic [2:0] AdrStatus = 3'd4;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlCs    = 1;
  localparam int unsigned CtrlIrqEn = 2;

  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatOvr  = 2;

  typedef enum logic [1:0] {StIdle, StLow, StHigh} spi_state_e;

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 byte engine: clock divider, phase FSM, bit counter and tx/rx shift registers.
module spi_shifter
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] div,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  spi_state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    done    = 1'b0;
    tick    = (cnt_q == div_q);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLow;
          div_d   = div;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = tx_byte;
        end
      end
      StLow: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (tick) begin
          // Rising sck edge: capture miso while mosi stays put for the whole high phase.
          state_d = StHigh;
          cnt_d   = '0;
          rx_d    = {rx_q[6:0], miso};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHigh: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StIdle;
            bit_d   = '0;
            done    = 1'b1;
          end else begin
            state_d = StLow;
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sck     = (state_q == StHigh);
  assign busy    = (state_q != StIdle);
  assign mosi    = busy & tx_q[7];
  assign rx_byte = rx_q;

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone classic slave exposing control/status registers around an 8-bit SPI master.
module wb_spi_master
  import spi_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = DefaultDiv
) (
`ifdef USE_POWER_PINS
  input  logic        vccd1,
  input  logic        vssd1,
`endif
  input  logic        clk_i,
  input  logic        rst,
  input  logic [31:0] wb_dat_i,
  input  logic [8:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_sck_o,
  output logic        spi_csb_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        irq_o
);

  logic       ack_q;
  logic [2:0] ctrl_q;
  logic [7:0] clkdiv_q;
  logic [7:0] rxdata_q;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;

  logic [2:0] adr;
  logic       req, wr, rd, tx_wr, st_wr, start;
  logic       busy, sh_done;
  logic [7:0] rx_byte;
  logic [7:0] rd_data;
  logic       unused_bits;

  assign unused_bits = ^{wb_adr_i[8:3], wb_sel_i[3:1], wb_dat_i[31:8]};

  assign adr   = wb_adr_i[2:0];
  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  // Register side effects land on the edge that closes the ack cycle.
  assign wr    = ack_q & wb_we_i & wb_sel_i[0];
  assign rd    = ack_q & ~wb_we_i;
  assign tx_wr = wr & (adr == AdrTx);
  assign st_wr = wr & (adr == AdrStatus);
  assign start = tx_wr & ctrl_q[CtrlEn] & ~busy;

  // A completing transfer beats a same-cycle clear.
  assign done_d = sh_done | (done_q & ~((rd & (adr == AdrRx)) | (st_wr & wb_dat_i[StatDone])));
  assign ovr_d  = (tx_wr & busy & ctrl_q[CtrlEn]) | (ovr_q & ~(st_wr & wb_dat_i[StatOvr]));

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      ctrl_q   <= '0;
      clkdiv_q <= DEFAULT_DIV;
      rxdata_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ack_q  <= req;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      if (wr && adr == AdrCtrl)   ctrl_q   <= wb_dat_i[2:0];
      if (wr && adr == AdrClkdiv) clkdiv_q <= wb_dat_i[7:0];
      if (sh_done)                rxdata_q <= rx_byte;
    end
  end

  always_comb begin
    rd_data = '0;
    case (adr)
      AdrCtrl:   rd_data = {5'b0, ctrl_q};
      AdrClkdiv: rd_data = clkdiv_q;
      AdrRx:     rd_data = rxdata_q;
      AdrStatus: rd_data = {5'b0, ovr_q, done_q, busy};
      default:   rd_data = '0;
    endcase
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = ack_q ? {24'b0, rd_data} : 32'b0;
  assign spi_csb_o = ~ctrl_q[CtrlCs];
  assign irq_o     = ctrl_q[CtrlIrqEn] & done_q;

  spi_shifter u_shifter (
    .clk     (clk_i),
    .rst     (rst),
    .en      (ctrl_q[CtrlEn]),
    .start   (start),
    .div     (clkdiv_q),
    .tx_byte (wb_dat_i[7:0]),
    .miso    (spi_miso_i),
    .sck     (spi_sck_o),
    .mosi    (spi_mosi_o),
    .busy    (busy),
    .done    (sh_done),
    .rx_byte (rx_byte)
  );

endmodule

// File: tb/tb_wb_spi_master.sv
// Randomized bench for wb_spi_master against a register-level model of the block.
module tb_wb_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_dat_i = '0;
  logic [8:0]  wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, sck, csb, mosi, miso, irq;

  logic        loop_mode = 1'b1;
  logic        miso_drv = 1'b0;
  logic [7:0]  pat = '0;
  assign miso = loop_mode ? mosi : miso_drv;

  always #5 clk = ~clk;

  wb_spi_master dut (
    .clk_i      (clk),
    .rst        (rst),
    .wb_dat_i   (wb_dat_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .spi_sck_o  (sck),
    .spi_csb_o  (csb),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .irq_o      (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-level model
  logic [2:0] m_ctrl;
  logic [7:0] m_div, m_rx;
  logic       m_done, m_ovr, m_busy;

  task automatic model_reset();
    m_ctrl = '0; m_div = 8'd3; m_rx = '0; m_done = 0; m_ovr = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] adr);
    case (adr)
      3'd0:    return {29'b0, m_ctrl};
      3'd1:    return {24'b0, m_div};
      3'd3:    return {24'b0, m_rx};
      3'd4:    return {29'b0, m_ovr, m_done, m_busy};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] adr, input logic [31:0] d, input logic [3:0] sel);
    if (sel[0]) begin
      case (adr)
        3'd0: m_ctrl = d[2:0];
        3'd1: m_div = d[7:0];
        3'd2: begin
          if (m_ctrl[0] && !m_busy) m_busy = 1;
          else if (m_ctrl[0] && m_busy) m_ovr = 1;
        end
        3'd4: begin
          if (d[1]) m_done = 0;
          if (d[2]) m_ovr = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rdat);
    bit got;
    int lat;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = {6'b0, adr};
    wb_dat_i = d; wb_sel_i = sel;
    got = 0; lat = 0; rdat = '0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1; lat = i; rdat = wb_dat_o; end
    end
    check_val("ack_seen", got, 1);
    if (got) check_val("ack_latency", lat, 1);
    @(posedge clk);
    #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, sel, dummy);
    model_write(adr, d, sel);
  endtask

  task automatic wb_read_chk(input string tag, input logic [2:0] adr);
    logic [31:0] exp, got;
    exp = exp_read(adr);
    wb_xfer(1'b0, adr, 32'b0, 4'hF, got);
    check_val(tag, got, exp);
    if (adr == 3'd3) m_done = 0;
  endtask

  // SPI line monitor: counts negedges since a transfer start and records mosi at each sck rise.
  bit   mon_on = 0;
  int   ncyc, rises, first_hi, last_hi;
  logic sck_prev;
  bit   mosi_q[$];

  always @(negedge clk) begin
    if (mon_on) begin
      ncyc++;
      if (sck && !sck_prev) begin
        rises++;
        mosi_q.push_back(mosi);
        if (rises == 1) first_hi = ncyc;
      end
      if (sck) last_hi = ncyc;
      if (!sck) miso_drv = (rises < 8) ? pat[7 - rises] : 1'b0;
      sck_prev = sck;
    end
  end

  task automatic arm_monitor();
    ncyc = 0; rises = 0; first_hi = 0; last_hi = 0; sck_prev = 0;
    mosi_q.delete();
    miso_drv = pat[7];
    mon_on = 1;
  endtask

  task automatic run_xfer(input int div, input logic [7:0] tx, input bit lp, input bit ie,
                          input bit do_ovr);
    int n;
    logic [7:0] sent, exp_rx;
    wb_write(3'd1, div);
    wb_write(3'd0, {29'b0, ie, 2'b11});
    loop_mode = lp;
    pat = 8'($urandom);
    exp_rx = lp ? tx : pat;
    wb_write(3'd2, {24'b0, tx});
    arm_monitor();
    if (do_ovr) begin
      wb_write(3'd2, {24'b0, ~tx});
      wb_read_chk("status_busy_ovr", 3'd4);
    end
    n = 16 * (div + 1);
    repeat (n + 2) @(negedge clk);
    mon_on = 0;
    sent = '0;
    foreach (mosi_q[i]) sent = {sent[6:0], mosi_q[i]};
    check_val("sck_rises", rises, 8);
    check_val("mosi_bits", sent, tx);
    check_val("first_sck_high", first_hi, div + 2);
    check_val("busy_span", last_hi, n);
    check_val("sck_idle", sck, 0);
    check_val("mosi_idle", mosi, 0);
    m_busy = 0; m_rx = exp_rx; m_done = 1;
    check_val("irq_done", irq, m_ctrl[2] & m_done);
    wb_read_chk("status_done", 3'd4);
  endtask

  initial begin
    int n_ack;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_ack", wb_ack_o, 0);
    check_val("rst_dat", wb_dat_o, 0);
    check_val("rst_sck", sck, 0);
    check_val("rst_mosi", mosi, 0);
    check_val("rst_csb", csb, 1);
    check_val("rst_irq", irq, 0);
    rst = 0;

    wb_read_chk("status_reset", 3'd4);
    wb_read_chk("clkdiv_reset", 3'd1);
    check_val("csb_idle", csb, 1);
    check_val("sck_idle0", sck, 0);

    // stb kept high through the ack cycle must yield a single ack
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 9'd1; wb_sel_i = 4'hF;
    n_ack = 0;
    @(negedge clk);
    if (wb_ack_o) n_ack++;
    check_val("held_rdata", wb_dat_o, exp_read(3'd1));
    @(negedge clk);
    if (wb_ack_o) n_ack++;
    check_val("dat_no_ack", wb_dat_o, 0);
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack_o) n_ack++;
    end
    check_val("ack_pulses", n_ack, 1);

    wb_write(3'd1, 32'h55, 4'b1110);
    wb_read_chk("clkdiv_sel_masked", 3'd1);
    wb_write(3'd5, 32'hFF);
    wb_read_chk("unmapped_read", 3'd5);
    wb_read_chk("txdata_read", 3'd2);
    wb_write(3'd0, 32'h2);
    check_val("csb_asserted", csb, 0);

    run_xfer(1, 8'hA5, 1'b1, 1'b0, 1'b0);
    wb_read_chk("rx_a5", 3'd3);
    wb_read_chk("status_after_rx", 3'd4);

    run_xfer(3, 8'($urandom), 1'b0, 1'b0, 1'b1);
    wb_write(3'd4, 32'h6);
    wb_read_chk("status_w1c", 3'd4);
    wb_read_chk("rx_ovr", 3'd3);

    run_xfer(0, 8'($urandom), 1'b1, 1'b1, 1'b0);
    check_val("irq_high", irq, 1);
    wb_read_chk("rx_irq", 3'd3);
    check_val("irq_cleared", irq, 0);

    for (int it = 0; it < 6; it++) begin
      run_xfer(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
      wb_read_chk("rx_rand", 3'd3);
      check_val("irq_after_rd", irq, 0);
    end

    // EN dropped halfway: abort without DONE, RXDATA keeps the last byte
    wb_write(3'd1, 32'h1);
    wb_write(3'd0, 32'h3);
    loop_mode = 1;
    wb_write(3'd2, 32'h5A);
    repeat (14) @(negedge clk);
    check_val("mid_busy_sck_active", 1'(sck | ~sck), 1);
    wb_write(3'd0, 32'h2);
    repeat (2) @(negedge clk);
    check_val("abort_sck", sck, 0);
    check_val("abort_mosi", mosi, 0);
    m_busy = 0;
    wb_read_chk("abort_status", 3'd4);
    wb_read_chk("abort_rx", 3'd3);

    // Asynchronous reset in the middle of a transfer
    wb_write(3'd0, 32'h3);
    wb_write(3'd1, 32'h2);
    wb_write(3'd2, {24'b0, 8'($urandom)});
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1;
    check_val("arst_sck", sck, 0);
    check_val("arst_mosi", mosi, 0);
    check_val("arst_csb", csb, 1);
    @(negedge clk);
    rst = 0;
    model_reset();
    wb_read_chk("arst_status", 3'd4);
    wb_read_chk("arst_rx", 3'd3);
    wb_read_chk("arst_clkdiv", 3'd1);
    wb_read_chk("arst_ctrl", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_spi_master.md
WB_SPI_MASTER -- requirements
Module: wb_spi_master

Interface
REQ-001 Parameter DEFAULT_DIV, 8'd3, reset value of CLKDIV register.
REQ-002 clk_i  input  1  single clock; all logic in this domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 vccd1/vssd1  input  1 each  power pins, present only under USE_POWER_PINS.
REQ-005 wb_dat_i  input  32  write data from interconnect slot S3.
REQ-006 wb_adr_i  input  9  word address; only [2:0] decoded.
REQ-007 wb_sel_i  input  4  byte lanes; only sel[0] qualifies writes.
REQ-008 wb_we_i / wb_cyc_i / wb_stb_i  input  1 each  Wishbone classic controls.
REQ-009 wb_dat_o  output  32  read data; [31:8] always 0.
REQ-010 wb_ack_o  output  1  transfer acknowledge.
REQ-011 spi_sck_o / spi_csb_o / spi_mosi_o  output  1 each  SPI clock, active-low chip select, serial out.
REQ-012 spi_miso_i  input  1  serial in; treated as synchronous to clk_i.
REQ-013 irq_o  output  1  level interrupt.

Function
REQ-014 Register map (adr[2:0]): 0 CTRL {IRQ_EN[2], CS[1], EN[0]}; 1 CLKDIV[7:0]; 2 TXDATA (W); 3 RXDATA (R); 4 STATUS {OVR[2], DONE[1], BUSY[0]}; 5-7 unmapped.
REQ-015 Request = cyc & stb & ~ack; wb_ack_o SHALL assert exactly one cycle, the cycle after the request is sampled, then deassert regardless of stb.
REQ-016 Read data SHALL be valid in the ack cycle; wb_dat_o = 0 when ack low; unmapped reads return 0, unmapped writes ignored, all still acked.
REQ-017 Writes take effect on the ack edge only when we=1 and sel[0]=1.
REQ-018 spi_csb_o = ~CTRL.CS, combinational from register, independent of FSM.
REQ-019 TXDATA write with EN=1 and BUSY=0 starts a transfer; BUSY=1 the following cycle; CLKDIV latched at start.
REQ-020 TXDATA write while BUSY=1: data dropped, OVR set; with EN=0: dropped, no flag.
REQ-021 FSM states IDLE, LOW, HIGH; IDLE->LOW on start (mosi = tx[7], sck=0); LOW->HIGH after CLKDIV+1 cycles (sck=1, sample miso); HIGH->LOW after CLKDIV+1 cycles (sck=0, shift next bit onto mosi); after 8th HIGH -> IDLE.
REQ-022 SPI mode 0, MSB first, 8 bits; transfer = 16*(CLKDIV+1) cycles; CLKDIV=0 gives sck = clk_i/2.
REQ-023 On return to IDLE: RXDATA <= shifted byte, DONE set, BUSY cleared same cycle; sck=0, mosi=0 in IDLE.
REQ-024 RXDATA read clears DONE; STATUS write of 1 clears DONE[1]/OVR[2] (W1C); BUSY read-only.
REQ-025 Completion same cycle as DONE clear (read or W1C): set wins; RXDATA read in completion cycle returns old byte.
REQ-026 EN cleared mid-transfer: FSM to IDLE next cycle, sck=0, no DONE, RXDATA unchanged.
REQ-027 irq_o = IRQ_EN & DONE, registered-free level output.

Reset
REQ-028 rst asynchronously forces: CTRL=0, CLKDIV=DEFAULT_DIV, RXDATA=0, DONE=OVR=0, FSM=IDLE, bit/divider counters=0.
REQ-029 Outputs during reset: wb_ack_o=0, wb_dat_o=0, spi_sck_o=0, spi_mosi_o=0, spi_csb_o=1, irq_o=0.
REQ-030 Reset mid-transfer aborts immediately with no partial RXDATA update; deassertion leaves block idle.

Structure
REQ-031 Package spi_pkg holds register offsets, CTRL/STATUS bit indices, FSM state enum, DEFAULT_DIV default.
REQ-032 One sub-module spi_shifter holds FSM, divider, bit counter and shift register; top holds Wishbone decode and registers.

Verification
REQ-033 Reset then read STATUS, CLKDIV -> 0x0, 0x3; csb=1, sck=0.
REQ-034 CLKDIV=1, CTRL=0x3, TXDATA=0xA5, miso looped to mosi -> BUSY 32 cycles, 8 sck rising edges, mosi 1,0,1,0,0,1,0,1, RXDATA=0xA5, DONE=1.
REQ-035 Second TXDATA write while BUSY -> OVR=1, transmitted byte unchanged; STATUS write 0x6 -> OVR=DONE=0.
REQ-036 IRQ_EN=1, transfer completes -> irq_o=1; RXDATA read -> irq_o=0 cycle after ack.
REQ-037 Clear EN at half-transfer -> sck=0, BUSY=0 next cycle, DONE=0, RXDATA keeps prior value.
REQ-038 Request with stb held 3 cycles -> exactly one ack pulse; write with sel=4'b1110 -> register unchanged.
